// File: rtl/mult_secuencial_param.sv
`timescale 1ns/1ps
// Parametrised sequential shift-add multiplier with signed/unsigned mode,
// optional early termination and a per-operation iteration count.
//
// state  | meaning
// -------+--------------------------------------------------------------
// S_IDLE | waiting for valid_data; operands captured as magnitudes
// S_BUSY | one shift-add iteration per cycle over the multiplier bits
// S_FIX  | apply sign to the magnitude product, publish result and count
// S_DONE | result held with Done_Flag until ack
module mult_secuencial_param #(
  parameter int size       = 32,
  parameter int EARLY_TERM = 1,
  parameter int CNT_W      = 6
) (
  input  logic                clk,
  input  logic                reset,
  input  logic [size-1:0]     a,
  input  logic [size-1:0]     b,
  input  logic                signed_mode,
  input  logic                valid_data,
  input  logic                ack,
  output logic                ret_ack,
  output logic                Done_Flag,
  output logic [2*size-1:0]   prod,
  output logic [CNT_W-1:0]    busy_cycles
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_BUSY = 2'd1,
    S_FIX  = 2'd2,
    S_DONE = 2'd3
  } state_t;

  localparam logic [CNT_W-1:0]  LAST_CNT = CNT_W'(size - 1);
  localparam logic [2*size-1:0] ONE_W    = (2*size)'(1);

  state_t              state_q,  state_d;
  logic [2*size-1:0]   mcand_q,  mcand_d;
  logic [size-1:0]     mplier_q, mplier_d;
  logic [2*size-1:0]   acc_q,    acc_d;
  logic [CNT_W-1:0]    cnt_q,    cnt_d;
  logic                neg_q,    neg_d;
  logic                ret_ack_q, ret_ack_d;
  logic                done_q,   done_d;
  logic [2*size-1:0]   prod_q,   prod_d;
  logic [CNT_W-1:0]    busy_q,   busy_d;

  logic [size-1:0]     a_abs;
  logic [size-1:0]     b_abs;

  // Magnitudes: the most negative value wraps to 2^(size-1), which is
  // exactly right when the result is reinterpreted as unsigned.
  always_comb begin
    a_abs = (signed_mode && a[size-1]) ? (~a + size'(1)) : a;
    b_abs = (signed_mode && b[size-1]) ? (~b + size'(1)) : b;
  end

  always_comb begin
    state_d   = state_q;
    mcand_d   = mcand_q;
    mplier_d  = mplier_q;
    acc_d     = acc_q;
    cnt_d     = cnt_q;
    neg_d     = neg_q;
    ret_ack_d = 1'b0;
    done_d    = done_q;
    prod_d    = prod_q;
    busy_d    = busy_q;

    case (state_q)
      S_IDLE: begin
        if (valid_data) begin
          mcand_d   = {{size{1'b0}}, a_abs};
          mplier_d  = b_abs;
          neg_d     = signed_mode & (a[size-1] ^ b[size-1]);
          acc_d     = '0;
          cnt_d     = '0;
          ret_ack_d = 1'b1;
          state_d   = S_BUSY;
        end
      end

      S_BUSY: begin
        if (mplier_q[0]) begin
          acc_d = acc_q + mcand_q;
        end
        mcand_d  = mcand_q << 1;
        mplier_d = mplier_q >> 1;
        cnt_d    = cnt_q + CNT_W'(1);
        if ((cnt_q == LAST_CNT) || ((EARLY_TERM != 0) && ((mplier_q >> 1) == '0))) begin
          state_d = S_FIX;
        end
      end

      S_FIX: begin
        // cnt already holds the number of BUSY iterations taken
        prod_d  = neg_q ? (~acc_q + ONE_W) : acc_q;
        busy_d  = cnt_q;
        done_d  = 1'b1;
        state_d = S_DONE;
      end

      S_DONE: begin
        if (ack) begin
          done_d  = 1'b0;
          state_d = S_IDLE;
        end
      end

      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= S_IDLE;
      mcand_q   <= '0;
      mplier_q  <= '0;
      acc_q     <= '0;
      cnt_q     <= '0;
      neg_q     <= 1'b0;
      ret_ack_q <= 1'b0;
      done_q    <= 1'b0;
      prod_q    <= '0;
      busy_q    <= '0;
    end else begin
      state_q   <= state_d;
      mcand_q   <= mcand_d;
      mplier_q  <= mplier_d;
      acc_q     <= acc_d;
      cnt_q     <= cnt_d;
      neg_q     <= neg_d;
      ret_ack_q <= ret_ack_d;
      done_q    <= done_d;
      prod_q    <= prod_d;
      busy_q    <= busy_d;
    end
  end

  assign ret_ack     = ret_ack_q;
  assign Done_Flag   = done_q;
  assign prod        = prod_q;
  assign busy_cycles = busy_q;

endmodule
